// File: rtl/difftest_pkg.sv
// rtl/difftest_pkg.sv - shared types and constants for difftest event collectors
//
// lrsc_entry_t is sized for the widest configuration (8 channels, 32-bit
// sequence numbers); each collector uses the low bits it needs.

package difftest_pkg;

    localparam int DIFFTEST_DROP_W = 16;

    // Widest channel index (8 channels) and widest supported sequence number.
    localparam int LRSC_CH_W  = 3;
    localparam int LRSC_SEQ_W = 32;

    typedef struct packed {
        logic                  success;
        logic [7:0]            coreid;
        logic [LRSC_CH_W-1:0]  channel;
        logic [LRSC_SEQ_W-1:0] seq;
    } lrsc_entry_t;

endpackage

// File: rtl/difftest_event_fifo.sv
// rtl/difftest_event_fifo.sv - multi-write / single-read FIFO with level output
//
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   wr_count       : number of entries written this cycle, taken from
//                    wr_data[0 .. wr_count-1]; the caller never exceeds free space
//   wr_data        : compacted write payloads
//   rd_en          : pop the head entry (ignored while empty)
//   rd_data        : head entry (registered storage, no bypass)
//   level          : current occupancy, 0..DEPTH

module difftest_event_fifo #(
    parameter type T        = logic [7:0],
    parameter int  DEPTH    = 8,
    parameter int  WR_PORTS = 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int LVL_W    = PTR_W + 1,
    localparam int CNT_W    = $clog2(WR_PORTS + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] wr_count,
    input  T                 wr_data [WR_PORTS],
    input  logic             rd_en,
    output T                 rd_data,
    output logic [LVL_W-1:0] level
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_rd;

    assign do_rd   = rd_en && (level != '0);
    assign rd_data = mem[head];

    // Storage is not reset; entries are only observable once written.
    always_ff @(posedge clock) begin
        for (int k = 0; k < WR_PORTS; k++) begin
            if (CNT_W'(k) < wr_count) begin
                mem[tail + PTR_W'(k)] <= wr_data[k];
            end
        end
    end

    // Pointers are PTR_W bits wide and wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            tail  <= tail + PTR_W'(wr_count);
            head  <= head + PTR_W'(do_rd);
            level <= level + LVL_W'(wr_count) - LVL_W'(do_rd);
        end
    end

endmodule

// File: rtl/difftest_lrsc_event_queue.sv
// rtl/difftest_lrsc_event_queue.sv - buffered collector for LR/SC difftest events
//
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   enable                : difftest enable; inputs ignored when low, draining continues
//   in_valid/in_success   : per-channel LR/SC completion and SC success bit
//   in_coreid             : core id shared by all channels
//   out_valid/out_ready   : head-entry handshake towards the difftest transport
//   out_success/out_coreid/out_channel/out_seq : head entry payload
//   level                 : queue occupancy
//   overflow              : sticky, set on the first dropped event
//   drop_count            : saturating number of dropped events
//
// Every offered event consumes a sequence number even when dropped, so the
// checker sees drops as gaps in out_seq.

module difftest_lrsc_event_queue
    import difftest_pkg::*;
#(
    parameter int  NUM_CH = 2,
    parameter int  DEPTH  = 8,
    parameter int  SEQ_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH-1:0]          in_success,
    input  logic [7:0]                 in_coreid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_success,
    output logic [7:0]                 out_coreid,
    output logic [CH_W-1:0]            out_channel,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [LVL_W-1:0]           level,
    output logic                       overflow,
    output logic [DIFFTEST_DROP_W-1:0] drop_count
);

    localparam int CNT_W  = $clog2(NUM_CH + 1);
    localparam int CALC_W = 16;
    localparam int SUM_W  = DIFFTEST_DROP_W + 1;

    logic [NUM_CH-1:0]  offered;
    logic [CNT_W-1:0]   prefix [NUM_CH];
    logic [CNT_W-1:0]   n_offered;
    logic [CALC_W-1:0]  free_slots;
    logic [CALC_W-1:0]  n_wide;
    logic [CALC_W-1:0]  accepted;
    logic [CALC_W-1:0]  dropped;
    logic [CNT_W-1:0]   wr_count;
    logic [SUM_W-1:0]   drop_sum;
    logic [SEQ_W-1:0]   seq_ctr;
    lrsc_entry_t        wr_data [NUM_CH];
    lrsc_entry_t        head_entry;
    logic [LRSC_CH_W+LRSC_SEQ_W-1:0] unused_head_fields;

    // prefix[i] = number of offered events on channels below i; it is both the
    // compaction slot and the sequence offset of channel i.
    always_comb begin
        offered   = in_valid & {NUM_CH{enable}};
        n_offered = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            prefix[i] = n_offered;
            n_offered = n_offered + CNT_W'(offered[i]);
        end
    end

    // Free space comes from the registered level only: a same-cycle dequeue
    // does not make room for this cycle's enqueue.
    always_comb begin
        free_slots = CALC_W'(DEPTH) - CALC_W'(level);
        n_wide     = CALC_W'(n_offered);
        accepted   = (n_wide < free_slots) ? n_wide : free_slots;
        dropped    = n_wide - accepted;
        wr_count   = CNT_W'(accepted);
        drop_sum   = SUM_W'(drop_count) + SUM_W'(dropped);
    end

    // Slot s carries the offered channel whose prefix count is s. Slots at or
    // beyond wr_count are ignored by the FIFO, which is how drops happen.
    always_comb begin
        for (int s = 0; s < NUM_CH; s++) begin
            wr_data[s] = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (offered[i] && (prefix[i] == CNT_W'(s))) begin
                    wr_data[s].success = in_success[i];
                    wr_data[s].coreid  = in_coreid;
                    wr_data[s].channel = LRSC_CH_W'(i);
                    wr_data[s].seq     = LRSC_SEQ_W'(seq_ctr + SEQ_W'(prefix[i]));
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seq_ctr    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            seq_ctr <= seq_ctr + SEQ_W'(n_offered);
            if (dropped != '0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[SUM_W-1] ? '1 : drop_sum[DIFFTEST_DROP_W-1:0];
            end
        end
    end

    difftest_event_fifo #(
        .T        (lrsc_entry_t),
        .DEPTH    (DEPTH),
        .WR_PORTS (NUM_CH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_count (wr_count),
        .wr_data  (wr_data),
        .rd_en    (out_ready),
        .rd_data  (head_entry),
        .level    (level)
    );

    assign out_valid   = (level != '0);
    assign out_success = head_entry.success;
    assign out_coreid  = head_entry.coreid;
    assign out_channel = head_entry.channel[CH_W-1:0];
    assign out_seq     = head_entry.seq[SEQ_W-1:0];

    // Upper channel/sequence bits are zero padding for narrower configurations.
    assign unused_head_fields = {head_entry.channel, head_entry.seq};

endmodule

// File: doc/difftest_lrsc_event_queue.md
# difftest_lrsc_event_queue

Parametrised, buffered collector for LR/SC difftest events. It accepts up to NUM_CH LR/SC completions per cycle from the core's commit ports and tags each one with a per-core sequence number. Accepted events are stored in a DEPTH-entry queue and drained one per cycle over a valid/ready port to the difftest transport (DPI bridge or batch packer). Lost events are reported through a sticky overflow flag and a saturating drop counter, and they leave sequence gaps the checker can see.

## Interface
Parameters:
- NUM_CH, default 2: number of LR/SC event channels per cycle (1..8).
- DEPTH, default 8: queue entries; must be a power of two, at least 2.
- SEQ_W, default 16: sequence-number width.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  difftest enable; when 0, inputs are ignored and draining continues.
- in_valid  in  NUM_CH  per-channel event valid.
- in_success  in  NUM_CH  per-channel SC success bit (LR reports 1).
- in_coreid  in  8  core id, common to all channels.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_success  out  1  head success bit.
- out_coreid  out  8  head core id.
- out_channel  out  max(1,clog2(NUM_CH))  channel index the head entry arrived on.
- out_seq  out  SEQ_W  head sequence number.
- level  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set on the first dropped event.
- drop_count  out  16  saturating count of dropped events.

## Operation
- Offered events: n = popcount(in_valid & {NUM_CH{enable}}).
- Enqueue space: free = DEPTH - level, taken from the registered level. A dequeue in the same cycle does not create space for that cycle's enqueue.
- Accepted events: the first min(n, free) valid channels, in ascending channel index, are written at consecutive tail slots. Compaction is by prefix count over in_valid.
- Dropped events: the remaining n - free events (when positive) are dropped.
  - drop_count increases by the dropped number and saturates at 0xFFFF.
  - overflow is set and stays set until reset.
- Sequence numbers: every offered event, accepted or dropped, consumes one. The k-th valid channel (ascending) gets seq_ctr + k, and seq_ctr then advances by n. Arithmetic is modulo 2^SEQ_W.
- Output port:
  - out_valid = (level != 0).
  - out_* fields are driven from the head entry.
  - A dequeue happens when out_valid && out_ready. out_ready while empty has no effect.
  - Output payload is stable while out_valid && !out_ready.
- Pointers: head and tail are clog2(DEPTH)-bit counters that wrap naturally. level is next_level = level + accepted - dequeued.
- Reset: asynchronous assertion clears head, tail, level, seq_ctr, overflow and drop_count to 0. Storage contents are don't-care. Outputs read out_valid=0, level=0, overflow=0, drop_count=0.
- Reset mid-operation: any queued events are lost without being counted as drops.

## Timing
- Latency: an event accepted at edge t is visible on out_* after edge t, with out_valid high in cycle t+1.
- Throughput: sustained 1 event per cycle drained; up to NUM_CH events per cycle enqueued.
- Full queue (level == DEPTH): all offered events drop; a simultaneous dequeue still occurs.
- Empty queue (level == 0): an enqueued event never bypasses the queue combinationally; it appears one cycle later.
- enable=0: in_valid is treated as 0, seq_ctr holds, and dequeue proceeds normally.
- Reset release is synchronised externally; the block performs no deassertion synchronisation.

## Structure
- Shared package difftest_pkg holds:
  - typedef lrsc_entry_t {success, coreid[7:0], channel, seq[SEQ_W-1:0]};
  - constant DIFFTEST_DROP_W = 16.
- Sub-module difftest_event_fifo is a generic multi-write/single-read FIFO: parametrised entry type, DEPTH and write ports, with registered storage and level output.
- The top level contains the prefix-count compaction, sequence assignment and drop accounting.

## Test plan
- Single channel, NUM_CH=2, DEPTH=8: in_valid=2'b01 for one cycle, out_ready=1 -> out_valid high next cycle, out_seq=0, out_channel=0, then level returns to 0.
- Both channels valid with success=2'b10 for one cycle -> two entries in order: (ch0, success 0, seq 0) then (ch1, success 1, seq 1), drained on consecutive cycles.
- out_ready=0, 2'b11 for 5 cycles -> 8 accepted (seq 0..7) and 2 dropped; overflow=1, drop_count=2, level=8. Draining then shows seq 0..7 with no repeats.
- Full queue, out_ready=1, in_valid=2'b11 in the same cycle -> one dequeue, both events dropped, level=7, and the next accepted event carries seq=10.
- seq_ctr preloaded near wrap by offering 65535 events -> the next pair is tagged 0xFFFF and 0x0000.
- reset_n pulsed low mid-burst with level=5 -> out_valid=0, level=0, overflow=0 and drop_count=0 immediately; after release the first event is tagged seq=0.
